// File: rtl/cdb_pkg.sv
// Shared definitions for the common-data-bus arbiter: default widths,
// the broadcast record and a one-hot test used on granted tags.
// Build option: CDB_FIXED_PRIORITY_EN selects fixed-priority arbitration.
package cdb_pkg;

  localparam int CDB_DATA_W    = 32;
  localparam int CDB_TAG_W     = 6;
  // Widest tag the one-hot helper accepts; narrower tags are zero-extended.
  localparam int CDB_MAX_TAG_W = 64;

  typedef struct packed {
    logic signed [CDB_DATA_W-1:0] data;
    logic        [CDB_TAG_W-1:0]  source;
    logic                         write;
  } cdb_bcast_t;

  // True when exactly one bit of the tag is set.
  function automatic logic is_onehot(input logic [CDB_MAX_TAG_W-1:0] tag);
    int n;
    n = 0;
    for (int i = 0; i < CDB_MAX_TAG_W; i++) begin
      if (tag[i]) n++;
    end
    return (n == 1);
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational picker: chooses one requester and returns it one-hot and
// as an index. Round-robin from ptr by default; with CDB_FIXED_PRIORITY_EN
// the lowest-index requester always wins and ptr is ignored.
module rr_picker
  import cdb_pkg::*;
#(
  parameter int N     = 2,
  parameter int PTR_W = 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [PTR_W-1:0] gnt_idx,
  output logic             gnt_any
);

`ifdef CDB_FIXED_PRIORITY_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr;
`endif

  // Walk candidates in search order and keep the first active request.
  always_comb begin
    int cand;
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    cand    = 0;
    for (int k = 0; k < N; k++) begin
`ifdef CDB_FIXED_PRIORITY_EN
      cand = k;
`else
      cand = (int'(ptr) + k) % N;
`endif
      if (!gnt_any && req[cand]) begin
        gnt_any   = 1'b1;
        gnt[cand] = 1'b1;
        gnt_idx   = cand[PTR_W-1:0];
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter. Grants one execution unit per cycle with a
// registered xmit pulse, samples the granted unit's result and tag during
// that pulse, and broadcasts them on the CDB the following cycle.
// Build option: CDB_FIXED_PRIORITY_EN (lowest index wins, no rr pointer).
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int NUM_UNITS = 2,
  parameter int DATA_W    = CDB_DATA_W,
  parameter int TAG_W     = CDB_TAG_W
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_UNITS-1:0]          unit_rts,
  input  logic [NUM_UNITS*DATA_W-1:0]   unit_data,
  input  logic [NUM_UNITS*TAG_W-1:0]    unit_tag,
  output logic [NUM_UNITS-1:0]          unit_xmit,
  output logic signed [DATA_W-1:0]      CDB_data,
  output logic [TAG_W-1:0]              CDB_source,
  output logic                          CDB_write,
  output logic                          tag_error
);

  localparam int PTR_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

  logic [NUM_UNITS-1:0] unit_xmit_q;
  logic [NUM_UNITS-1:0] mask_q;
  logic [NUM_UNITS-1:0] eligible;
  logic [NUM_UNITS-1:0] gnt;
  logic [PTR_W-1:0]     gnt_idx;
  logic                 gnt_any;
  logic [PTR_W-1:0]     ptr;

  logic [DATA_W-1:0]    data_slice [NUM_UNITS];
  logic [TAG_W-1:0]     tag_slice  [NUM_UNITS];
  logic [DATA_W-1:0]    sel_data;
  logic [TAG_W-1:0]     sel_tag;
  logic [CDB_MAX_TAG_W-1:0] tag_ext;

  logic [DATA_W-1:0]    cdb_data_q,  cdb_data_d;
  logic [TAG_W-1:0]     cdb_source_q, cdb_source_d;
  logic                 cdb_write_q, cdb_write_d;
  logic                 tag_error_q, tag_error_d;

  // A unit granted last cycle still holds rts while it sees xmit, so it is
  // masked for one cycle; this also lets lower-priority units in.
  assign eligible = unit_rts & ~mask_q;

  rr_picker #(
    .N     (NUM_UNITS),
    .PTR_W (PTR_W)
  ) u_picker (
    .req     (eligible),
    .ptr     (ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

`ifdef CDB_FIXED_PRIORITY_EN
  logic unused_idx;
  assign unused_idx = ^gnt_idx;
  assign ptr        = '0;
`else
  logic [PTR_W-1:0] ptr_q, ptr_d;

  // Next search starts just after the winner; idle cycles keep the pointer.
  always_comb begin
    ptr_d = ptr_q;
    if (gnt_any) begin
      if (gnt_idx == PTR_W'(NUM_UNITS - 1)) ptr_d = '0;
      else                                  ptr_d = gnt_idx + 1'b1;
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;
`endif

  // Grant pulse and cooldown mask both take the picker's choice.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      unit_xmit_q <= '0;
      mask_q      <= '0;
    end else begin
      unit_xmit_q <= gnt;
      mask_q      <= gnt;
    end
  end

  // Split the flat input buses into per-unit slices.
  for (genvar gi = 0; gi < NUM_UNITS; gi++) begin : g_slice
    assign data_slice[gi] = unit_data[gi*DATA_W +: DATA_W];
    assign tag_slice[gi]  = unit_tag[gi*TAG_W +: TAG_W];
  end

  // AND-OR mux of the unit currently seeing xmit (xmit is one-hot).
  always_comb begin
    sel_data = '0;
    sel_tag  = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (unit_xmit_q[i]) begin
        sel_data = sel_data | data_slice[i];
        sel_tag  = sel_tag  | tag_slice[i];
      end
    end
    tag_ext              = '0;
    tag_ext[TAG_W-1:0]   = sel_tag;
  end

  // Broadcast next state: capture on xmit, otherwise hold data/source.
  always_comb begin
    cdb_write_d  = |unit_xmit_q;
    cdb_data_d   = cdb_data_q;
    cdb_source_d = cdb_source_q;
    tag_error_d  = tag_error_q;
    if (|unit_xmit_q) begin
      cdb_data_d   = sel_data;
      cdb_source_d = sel_tag;
      if (!is_onehot(tag_ext)) tag_error_d = 1'b1;
    end
  end

  // CDB output registers and sticky tag error flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cdb_write_q  <= 1'b0;
      cdb_data_q   <= '0;
      cdb_source_q <= '0;
      tag_error_q  <= 1'b0;
    end else begin
      cdb_write_q  <= cdb_write_d;
      cdb_data_q   <= cdb_data_d;
      cdb_source_q <= cdb_source_d;
      tag_error_q  <= tag_error_d;
    end
  end

  assign unit_xmit  = unit_xmit_q;
  assign CDB_data   = cdb_data_q;
  assign CDB_source = cdb_source_q;
  assign CDB_write  = cdb_write_q;
  assign tag_error  = tag_error_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter with two units. Expected values are hand
// derived and hold for both round-robin and fixed-priority builds.
module tb_cdb_arbiter;

  localparam int N  = 2;
  localparam int DW = 32;
  localparam int TW = 6;

  logic                 clock = 1'b0;
  logic                 reset = 1'b1;
  logic [N-1:0]         unit_rts  = '0;
  logic [N*DW-1:0]      unit_data = '0;
  logic [N*TW-1:0]      unit_tag  = '0;
  logic [N-1:0]         unit_xmit;
  logic signed [DW-1:0] CDB_data;
  logic [TW-1:0]        CDB_source;
  logic                 CDB_write;
  logic                 tag_error;

  int checks   = 0;
  int failures = 0;

  cdb_arbiter #(.NUM_UNITS(N), .DATA_W(DW), .TAG_W(TW)) dut (
    .clock      (clock),
    .reset      (reset),
    .unit_rts   (unit_rts),
    .unit_data  (unit_data),
    .unit_tag   (unit_tag),
    .unit_xmit  (unit_xmit),
    .CDB_data   (CDB_data),
    .CDB_source (CDB_source),
    .CDB_write  (CDB_write),
    .tag_error  (tag_error)
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic set_unit(input int i, input logic rts, input logic signed [DW-1:0] d,
                          input logic [TW-1:0] t);
    unit_rts[i]         = rts;
    unit_data[i*DW +: DW] = d;
    unit_tag[i*TW +: TW]  = t;
  endtask

  task automatic apply_reset;
    reset     = 1'b1;
    unit_rts  = '0;
    unit_data = '0;
    unit_tag  = '0;
    tick;
    tick;
    reset = 1'b0;
    tick;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    set_unit(0, 1'b1, 32'sd77, 6'b000001);
    set_unit(1, 1'b1, 32'sd88, 6'b000010);
    tick;
    tick;
    checks++; if (unit_xmit !== 2'b00) begin failures++; $display("FAIL reset_xmit got=%b exp=00", unit_xmit); end
    checks++; if (CDB_write !== 1'b0) begin failures++; $display("FAIL reset_write got=%b exp=0", CDB_write); end
    checks++; if (CDB_data !== 32'sd0) begin failures++; $display("FAIL reset_data got=%0d exp=0", CDB_data); end
    checks++; if (CDB_source !== 6'b0) begin failures++; $display("FAIL reset_source got=%b exp=000000", CDB_source); end
    checks++; if (tag_error !== 1'b0) begin failures++; $display("FAIL reset_tag_error got=%b exp=0", tag_error); end
    $display("test_reset: outputs checked under reset");
  endtask

  task automatic test_single;
    apply_reset;
    set_unit(0, 1'b1, -32'sd7, 6'b000100);
    checks++; if (unit_xmit !== 2'b00 || CDB_write !== 1'b0) begin failures++; $display("FAIL single_t0 xmit=%b write=%b exp 00/0", unit_xmit, CDB_write); end
    tick; // t1
    checks++; if (unit_xmit !== 2'b01) begin failures++; $display("FAIL single_xmit_t1 got=%b exp=01", unit_xmit); end
    checks++; if (CDB_write !== 1'b0) begin failures++; $display("FAIL single_write_t1 got=%b exp=0", CDB_write); end
    tick; // t2
    unit_rts[0] = 1'b0;
    checks++; if (unit_xmit !== 2'b00) begin failures++; $display("FAIL single_xmit_t2 got=%b exp=00", unit_xmit); end
    checks++; if (CDB_write !== 1'b1 || CDB_data !== -32'sd7 || CDB_source !== 6'b000100) begin
      failures++; $display("FAIL single_bcast_t2 write=%b data=%0d src=%b exp 1/-7/000100", CDB_write, CDB_data, CDB_source); end
    for (int k = 3; k < 6; k++) begin
      tick;
      checks++; if (unit_xmit !== 2'b00 || CDB_write !== 1'b0 || CDB_data !== -32'sd7) begin
        failures++; $display("FAIL single_after t%0d xmit=%b write=%b data=%0d exp 00/0/-7", k, unit_xmit, CDB_write, CDB_data); end
    end
    $display("test_single: one grant, one broadcast of -7");
  endtask

  task automatic test_contention;
    apply_reset;
    set_unit(0, 1'b1, 32'sd5, 6'b000001);
    set_unit(1, 1'b1, 32'sd9, 6'b000010);
    tick; // t1
    checks++; if (unit_xmit !== 2'b01) begin failures++; $display("FAIL cont_xmit_t1 got=%b exp=01", unit_xmit); end
    tick; // t2
    unit_rts[0] = 1'b0;
    checks++; if (unit_xmit !== 2'b10) begin failures++; $display("FAIL cont_xmit_t2 got=%b exp=10", unit_xmit); end
    checks++; if (CDB_write !== 1'b1 || CDB_data !== 32'sd5 || CDB_source !== 6'b000001) begin
      failures++; $display("FAIL cont_bcast_t2 write=%b data=%0d src=%b exp 1/5/000001", CDB_write, CDB_data, CDB_source); end
    tick; // t3
    unit_rts[1] = 1'b0;
    checks++; if (unit_xmit !== 2'b00) begin failures++; $display("FAIL cont_xmit_t3 got=%b exp=00", unit_xmit); end
    checks++; if (CDB_write !== 1'b1 || CDB_data !== 32'sd9 || CDB_source !== 6'b000010) begin
      failures++; $display("FAIL cont_bcast_t3 write=%b data=%0d src=%b exp 1/9/000010", CDB_write, CDB_data, CDB_source); end
    tick; // t4
    checks++; if (CDB_write !== 1'b0) begin failures++; $display("FAIL cont_write_t4 got=%b exp=0", CDB_write); end
    // Pointer should be back at unit 0: a fresh double request grants 0 first.
    set_unit(0, 1'b1, 32'sd1, 6'b000001);
    set_unit(1, 1'b1, 32'sd2, 6'b000010);
    tick;
    checks++; if (unit_xmit !== 2'b01) begin failures++; $display("FAIL cont_ptr_back got=%b exp=01", unit_xmit); end
    unit_rts = '0;
    tick;
    tick;
    tick;
    $display("test_contention: grants 0 then 1, broadcasts 5 then 9");
  endtask

  task automatic test_fairness;
    logic [N-1:0] seen;
    int cnt [N];
    logic [N-1:0] exp_x;
    int u;
    int n;
    apply_reset;
    seen = '0;
    cnt[0] = 0;
    cnt[1] = 0;
    set_unit(0, 1'b1, 32'sd0,   6'b000001);
    set_unit(1, 1'b1, 32'sd100, 6'b000010);
    for (int k = 0; k <= 20; k++) begin
      // Units present their next result the cycle after seeing xmit.
      for (int i = 0; i < N; i++) begin
        if (seen[i]) begin
          cnt[i]++;
          unit_data[i*DW +: DW] = DW'(i * 100 + cnt[i]);
        end
      end
      exp_x = (k == 0) ? 2'b00 : (((k - 1) % 2 == 0) ? 2'b01 : 2'b10);
      checks++; if (unit_xmit !== exp_x) begin failures++; $display("FAIL fair_xmit t%0d got=%b exp=%b", k, unit_xmit, exp_x); end
      if (k >= 2) begin
        u = (k - 2) % 2;
        n = (k - 2) / 2;
        checks++;
        if (CDB_write !== 1'b1 || CDB_data !== DW'(u * 100 + n) || CDB_source !== ((u == 0) ? 6'b000001 : 6'b000010)) begin
          failures++; $display("FAIL fair_bcast t%0d write=%b data=%0d src=%b exp 1/%0d/unit%0d", k, CDB_write, CDB_data, CDB_source, u * 100 + n, u);
        end
      end
      seen = unit_xmit;
      tick;
    end
    unit_rts = '0;
    tick;
    tick;
    tick;
    checks++; if (unit_xmit !== 2'b00 || CDB_write !== 1'b0) begin failures++; $display("FAIL fair_drain xmit=%b write=%b exp 00/0", unit_xmit, CDB_write); end
    $display("test_fairness: 20 cycles of alternating grants");
  endtask

  task automatic test_bad_tag;
    apply_reset;
    set_unit(0, 1'b1, 32'sd3, 6'b000110);
    tick; // t1
    checks++; if (unit_xmit !== 2'b01 || tag_error !== 1'b0) begin failures++; $display("FAIL badtag_t1 xmit=%b err=%b exp 01/0", unit_xmit, tag_error); end
    tick; // t2
    unit_rts[0] = 1'b0;
    checks++; if (CDB_write !== 1'b1 || CDB_data !== 32'sd3 || CDB_source !== 6'b000110) begin
      failures++; $display("FAIL badtag_bcast write=%b data=%0d src=%b exp 1/3/000110", CDB_write, CDB_data, CDB_source); end
    checks++; if (tag_error !== 1'b1) begin failures++; $display("FAIL badtag_err_t2 got=%b exp=1", tag_error); end
    // A later good tag must not clear the sticky flag.
    tick;
    set_unit(1, 1'b1, 32'sd4, 6'b010000);
    tick;
    tick;
    unit_rts[1] = 1'b0;
    checks++; if (CDB_write !== 1'b1 || CDB_data !== 32'sd4) begin failures++; $display("FAIL badtag_good_bcast write=%b data=%0d exp 1/4", CDB_write, CDB_data); end
    for (int k = 0; k < 4; k++) tick;
    checks++; if (tag_error !== 1'b1) begin failures++; $display("FAIL badtag_sticky got=%b exp=1", tag_error); end
    apply_reset;
    checks++; if (tag_error !== 1'b0) begin failures++; $display("FAIL badtag_cleared got=%b exp=0", tag_error); end
    $display("test_bad_tag: non-one-hot tag flagged and sticky");
  endtask

  task automatic test_reset_midop;
    apply_reset;
    set_unit(0, 1'b1, 32'sd5, 6'b000001);
    set_unit(1, 1'b1, 32'sd9, 6'b000010);
    tick; // t1
    tick; // t2
    checks++; if (unit_xmit !== 2'b10 || CDB_data !== 32'sd5) begin failures++; $display("FAIL midop_pre xmit=%b data=%0d exp 10/5", unit_xmit, CDB_data); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (unit_xmit !== 2'b00 || CDB_write !== 1'b0) begin failures++; $display("FAIL midop_async xmit=%b write=%b exp 00/0", unit_xmit, CDB_write); end
    checks++; if (CDB_data !== 32'sd0 || CDB_source !== 6'b0 || tag_error !== 1'b0) begin
      failures++; $display("FAIL midop_async_bus data=%0d src=%b err=%b exp 0/0/0", CDB_data, CDB_source, tag_error); end
    unit_rts = '0;
    tick;
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick;
      checks++; if (unit_xmit !== 2'b00 || CDB_write !== 1'b0) begin failures++; $display("FAIL midop_quiet c%0d xmit=%b write=%b exp 00/0", k, unit_xmit, CDB_write); end
    end
    set_unit(0, 1'b1, 32'sd11, 6'b000100);
    tick;
    checks++; if (unit_xmit !== 2'b01) begin failures++; $display("FAIL midop_regrant got=%b exp=01", unit_xmit); end
    tick;
    unit_rts[0] = 1'b0;
    checks++; if (CDB_write !== 1'b1 || CDB_data !== 32'sd11) begin failures++; $display("FAIL midop_rebcast write=%b data=%0d exp 1/11", CDB_write, CDB_data); end
    $display("test_reset_midop: reset discards pending grant and broadcast");
  endtask

  task automatic test_idle;
    apply_reset;
    set_unit(0, 1'b1, 32'sd42, 6'b000001);
    tick;
    tick;
    unit_rts[0] = 1'b0;
    checks++; if (CDB_write !== 1'b1 || CDB_data !== 32'sd42) begin failures++; $display("FAIL idle_seed write=%b data=%0d exp 1/42", CDB_write, CDB_data); end
    for (int k = 0; k < 10; k++) begin
      tick;
      checks++;
      if (unit_xmit !== 2'b00 || CDB_write !== 1'b0 || CDB_data !== 32'sd42 || CDB_source !== 6'b000001) begin
        failures++; $display("FAIL idle c%0d xmit=%b write=%b data=%0d src=%b exp 00/0/42/000001", k, unit_xmit, CDB_write, CDB_data, CDB_source);
      end
    end
    $display("test_idle: bus holds 42 with no requests");
  endtask

  initial begin
    test_reset;
    test_single;
    test_contention;
    test_fairness;
    test_bad_tag;
    test_reset_midop;
    test_idle;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
